// File: rtl/vga_sync_monitor_if.sv
// vga_if: VGA output bundle as seen between the video pipeline and its monitor
interface vga_if;
    logic       vga_HS;
    logic       vga_VS;
    logic       vga_BLANK;
    logic [7:0] vga_R;
    logic [7:0] vga_G;
    logic [7:0] vga_B;
    modport master (output vga_HS, vga_VS, vga_BLANK, vga_R, vga_G, vga_B);
    modport slave  (input  vga_HS, vga_VS, vga_BLANK, vga_R, vga_G, vga_B);
endinterface

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: measures VGA line/frame timing, locks on the configured mode, checksums each frame
module vga_sync_monitor #(
    parameter int H_TOTAL         = 800,
    parameter int H_ACTIVE        = 640,
    parameter int V_TOTAL         = 525,
    parameter int V_ACTIVE        = 480,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    vga_if.slave        vga,
    input  logic        clear_errors,
    output logic        locked,
    output logic        frame_done,
    output logic [11:0] meas_h_total,
    output logic [11:0] meas_h_active,
    output logic [11:0] meas_v_total,
    output logic [11:0] meas_v_active,
    output logic [15:0] frame_checksum,
    output logic [15:0] frame_count,
    output logic        err_h,
    output logic        err_v
);
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
    state_t state, state_nxt;
    logic hs_q, vs_q, hs_p, vs_p, blank_q;
    logic [7:0] r_q, g_q, b_q;
    logic [11:0] h_cnt, h_act, v_cnt, v_act;
    logic [15:0] acc;
    logic frame_bad;
    logic hs_edge, vs_edge;
    logic [11:0] line_total, line_act, v_cnt_nxt, v_act_nxt;
    logic [15:0] acc_nxt;
    logic line_ok, line_bad, frame_match, frame_clean;
    logic cap_line, cap_frame, cnt_inc, err_h_set, err_v_set;

    // register the video pins once, with syncs normalised so 1 always means asserted
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            {hs_q, vs_q, hs_p, vs_p, blank_q} <= '0;
            {r_q, g_q, b_q} <= '0;
        end else begin
            hs_q    <= vga.vga_HS ^ SYNC_ACTIVE_LOW;
            vs_q    <= vga.vga_VS ^ SYNC_ACTIVE_LOW;
            hs_p    <= hs_q;
            vs_p    <= vs_q;
            blank_q <= vga.vga_BLANK;
            r_q     <= vga.vga_R;
            g_q     <= vga.vga_G;
            b_q     <= vga.vga_B;
        end
    end

    // per-cycle view of the line/frame being closed, including this cycle's contribution
    always_comb begin
        hs_edge     = hs_q & ~hs_p;
        vs_edge     = vs_q & ~vs_p;
        line_total  = &h_cnt ? h_cnt : h_cnt + 12'd1;
        line_act    = (&h_act || !blank_q) ? h_act : h_act + 12'd1;
        line_ok     = line_total == 12'(H_TOTAL) && (line_act == 12'd0 || line_act == 12'(H_ACTIVE));
        line_bad    = hs_edge & ~line_ok;
        v_cnt_nxt   = (hs_edge && !(&v_cnt)) ? v_cnt + 12'd1 : v_cnt;
        v_act_nxt   = (hs_edge && line_act != 12'd0 && !(&v_act)) ? v_act + 12'd1 : v_act;
        acc_nxt     = blank_q ? acc + 16'(r_q) + 16'(g_q) + 16'(b_q) : acc;
        frame_match = v_cnt_nxt == 12'(V_TOTAL) && v_act_nxt == 12'(V_ACTIVE);
        frame_clean = ~frame_bad & ~line_bad;
    end

    // horizontal counters restart after every HS edge and saturate if HS goes missing
    always_ff @(posedge clk_clk) begin
        if (reset_reset || hs_edge) begin
            h_cnt <= '0;
            h_act <= '0;
        end else begin
            h_cnt <= line_total;
            h_act <= line_act;
        end
    end

    // vertical counters, pixel accumulator and per-frame line health restart on every VS edge
    always_ff @(posedge clk_clk) begin
        if (reset_reset || vs_edge) begin
            v_cnt     <= '0;
            v_act     <= '0;
            acc       <= '0;
            frame_bad <= 1'b0;
        end else begin
            v_cnt     <= v_cnt_nxt;
            v_act     <= v_act_nxt;
            acc       <= acc_nxt;
            frame_bad <= frame_bad | line_bad;
        end
    end

    // lock state register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) state <= SEARCH;
        else state <= state_nxt;
    end

    // lock transitions: any bad line or frame while locked drops straight back to SEARCH
    always_comb begin
        state_nxt = state == SEARCH  ? (vs_edge ? ACQUIRE : SEARCH)
                  : state == ACQUIRE ? ((vs_edge && frame_match && frame_clean) ? LOCKED : ACQUIRE)
                  : (line_bad || (vs_edge && !frame_match)) ? SEARCH : LOCKED;
    end

    // state-derived strobes; measurements are ignored while searching
    always_comb begin
        locked    = state == LOCKED;
        cap_line  = hs_edge && state != SEARCH;
        cap_frame = vs_edge && state != SEARCH;
        cnt_inc   = cap_frame && state_nxt == LOCKED;
        err_h_set = locked && line_bad;
        err_v_set = locked && vs_edge && !frame_match;
    end

    // published measurements, frame counter and sticky error flags (a new error beats a clear)
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            frame_done     <= 1'b0;
            meas_h_total   <= '0;
            meas_h_active  <= '0;
            meas_v_total   <= '0;
            meas_v_active  <= '0;
            frame_checksum <= '0;
            frame_count    <= '0;
            err_h          <= 1'b0;
            err_v          <= 1'b0;
        end else begin
            frame_done <= cap_frame;
            if (cap_line) meas_h_total <= line_total;
            if (cap_line && line_act != 12'd0) meas_h_active <= line_act;
            if (cap_frame) begin
                meas_v_total   <= v_cnt_nxt;
                meas_v_active  <= v_act_nxt;
                frame_checksum <= acc_nxt;
            end
            if (cnt_inc) frame_count <= frame_count + 16'd1;
            err_h <= err_h_set | (err_h & ~clear_errors);
            err_v <= err_v_set | (err_v & ~clear_errors);
        end
    end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed checks of a shrunken 24x12 video mode on both sync polarities
module tb_vga_sync_monitor;
    logic clk = 1'b0;
    logic rst, clr;
    logic [7:0] cr, cg, cb;
    int pass_n = 0;
    int total_n = 0;
    vga_if v1 ();
    vga_if v0 ();
    logic l1, fd1, eh1, ev1, l0, fd0, eh0, ev0;
    logic [11:0] mht1, mha1, mvt1, mva1, mht0, mha0, mvt0, mva0;
    logic [15:0] cs1, fc1, cs0, fc0;

    vga_sync_monitor #(.H_TOTAL(24), .H_ACTIVE(16), .V_TOTAL(12), .V_ACTIVE(8), .SYNC_ACTIVE_LOW(1'b1)) u1 (
        .clk_clk(clk), .reset_reset(rst), .vga(v1.slave), .clear_errors(clr),
        .locked(l1), .frame_done(fd1), .meas_h_total(mht1), .meas_h_active(mha1),
        .meas_v_total(mvt1), .meas_v_active(mva1), .frame_checksum(cs1), .frame_count(fc1),
        .err_h(eh1), .err_v(ev1));

    vga_sync_monitor #(.H_TOTAL(24), .H_ACTIVE(16), .V_TOTAL(12), .V_ACTIVE(8), .SYNC_ACTIVE_LOW(1'b0)) u0 (
        .clk_clk(clk), .reset_reset(rst), .vga(v0.slave), .clear_errors(clr),
        .locked(l0), .frame_done(fd0), .meas_h_total(mht0), .meas_h_active(mha0),
        .meas_v_total(mvt0), .meas_v_active(mva0), .frame_checksum(cs0), .frame_count(fc0),
        .err_h(eh0), .err_v(ev0));

    always #5 clk = ~clk;

    // one pixel per clock: HS asserted x=18..20, VS asserted on lines 9..10, visible x<16 and y<8
    task automatic px(input int x, input int y);
        logic hs, vs, bl;
        @(negedge clk);
        hs = x >= 18 && x < 21;
        vs = y == 9 || y == 10;
        bl = x < 16 && y < 8;
        v1.vga_HS = ~hs; v1.vga_VS = ~vs; v0.vga_HS = hs; v0.vga_VS = vs;
        v1.vga_BLANK = bl; v0.vga_BLANK = bl;
        v1.vga_R = bl ? cr : 8'h55; v1.vga_G = bl ? cg : 8'h55; v1.vga_B = bl ? cb : 8'h55;
        v0.vga_R = v1.vga_R; v0.vga_G = v1.vga_G; v0.vga_B = v1.vga_B;
    endtask

    task automatic line(input int y, input int len);
        for (int x = 0; x < len; x++) px(x, y);
    endtask

    task automatic frame(input int nl);
        for (int y = 0; y < nl; y++) line(y, 24);
    endtask

    task automatic test_reset;
        rst = 1'b1; clr = 1'b0; cr = 8'd1; cg = 8'd2; cb = 8'd3;
        v1.vga_HS = 1'b1; v1.vga_VS = 1'b1; v0.vga_HS = 1'b0; v0.vga_VS = 1'b0;
        v1.vga_BLANK = 1'b0; v0.vga_BLANK = 1'b0;
        v1.vga_R = '0; v1.vga_G = '0; v1.vga_B = '0; v0.vga_R = '0; v0.vga_G = '0; v0.vga_B = '0;
        repeat (3) @(negedge clk);
        total_n++; if ({l1, fd1, eh1, ev1, mht1, mha1, mvt1, mva1, cs1, fc1} !== '0) $display("FAIL reset_lo: outputs=%h want 0", {l1, fd1, eh1, ev1, mht1, mha1, mvt1, mva1, cs1, fc1}); else pass_n++;
        total_n++; if ({l0, fd0, eh0, ev0, mht0, mha0, mvt0, mva0, cs0, fc0} !== '0) $display("FAIL reset_hi: outputs=%h want 0", {l0, fd0, eh0, ev0, mht0, mha0, mvt0, mva0, cs0, fc0}); else pass_n++;
        rst = 1'b0;
    endtask

    task automatic test_lock;
        frame(12);
        total_n++; if (l1 !== 1'b0 || fc1 !== 16'd0) $display("FAIL acquire: locked=%0b count=%0d want 0/0", l1, fc1); else pass_n++;
        for (int y = 0; y < 9; y++) line(y, 24);
        px(0, 9); px(1, 9);
        total_n++; if (l1 !== 1'b0 || fd1 !== 1'b0) $display("FAIL lock_early: locked=%0b done=%0b want 0/0", l1, fd1); else pass_n++;
        px(2, 9);
        total_n++; if (l1 !== 1'b1 || fd1 !== 1'b1) $display("FAIL lock_time: locked=%0b done=%0b want 1/1", l1, fd1); else pass_n++;
        total_n++; if ({mht1, mha1, mvt1, mva1} !== {12'd24, 12'd16, 12'd12, 12'd8}) $display("FAIL meas: h=%0d ha=%0d v=%0d va=%0d want 24/16/12/8", mht1, mha1, mvt1, mva1); else pass_n++;
        total_n++; if (fc1 !== 16'd1 || cs1 !== 16'h0300) $display("FAIL first_frame: count=%0d sum=%h want 1/0300", fc1, cs1); else pass_n++;
        total_n++; if (l0 !== 1'b1 || mvt0 !== 12'd12 || mht0 !== 12'd24 || cs0 !== 16'h0300) $display("FAIL hi_pol: locked=%0b v=%0d h=%0d sum=%h want 1/12/24/0300", l0, mvt0, mht0, cs0); else pass_n++;
        px(3, 9);
        total_n++; if (fd1 !== 1'b0) $display("FAIL done_pulse: done=%0b want 0", fd1); else pass_n++;
        for (int x = 4; x < 24; x++) px(x, 9);
        line(10, 24); line(11, 24);
        frame(12);
        total_n++; if (fc1 !== 16'd2 || l1 !== 1'b1) $display("FAIL count2: count=%0d locked=%0b want 2/1", fc1, l1); else pass_n++;
    endtask

    task automatic test_checksum;
        cr = 8'd255; cg = 8'd255; cb = 8'd255;
        frame(12);
        total_n++; if (cs1 !== 16'h7E80 || fc1 !== 16'd3) $display("FAIL checksum_wrap: sum=%h count=%0d want 7e80/3", cs1, fc1); else pass_n++;
        total_n++; if (cs0 !== 16'h7E80) $display("FAIL checksum_hi: sum=%h want 7e80", cs0); else pass_n++;
        cr = 8'd1; cg = 8'd2; cb = 8'd3;
    endtask

    task automatic test_line_error;
        line(0, 24); line(1, 24); line(2, 24); line(3, 25);
        for (int x = 0; x < 20; x++) px(x, 4);
        total_n++; if (l1 !== 1'b1 || eh1 !== 1'b0) $display("FAIL line_err_early: locked=%0b err_h=%0b want 1/0", l1, eh1); else pass_n++;
        px(20, 4);
        total_n++; if (l1 !== 1'b0 || eh1 !== 1'b1 || ev1 !== 1'b0 || mht1 !== 12'd25) $display("FAIL line_err: locked=%0b err_h=%0b err_v=%0b h=%0d want 0/1/0/25", l1, eh1, ev1, mht1); else pass_n++;
        for (int x = 21; x < 24; x++) px(x, 4);
        for (int y = 5; y < 12; y++) line(y, 24);
        total_n++; if (l1 !== 1'b0 || fc1 !== 16'd3) $display("FAIL line_err_hold: locked=%0b count=%0d want 0/3", l1, fc1); else pass_n++;
        frame(12);
        total_n++; if (l1 !== 1'b1 || eh1 !== 1'b1 || fc1 !== 16'd4) $display("FAIL relock: locked=%0b err_h=%0b count=%0d want 1/1/4", l1, eh1, fc1); else pass_n++;
    endtask

    task automatic test_clear;
        clr = 1'b1; px(0, 0); clr = 1'b0;
        total_n++; if (eh1 !== 1'b0) $display("FAIL clear: err_h=%0b want 0", eh1); else pass_n++;
        for (int x = 1; x < 24; x++) px(x, 0);
        line(1, 24); line(2, 24); line(3, 25);
        for (int x = 0; x < 20; x++) px(x, 4);
        clr = 1'b1; px(20, 4); clr = 1'b0;
        total_n++; if (eh1 !== 1'b1 || l1 !== 1'b0) $display("FAIL set_wins: err_h=%0b locked=%0b want 1/0", eh1, l1); else pass_n++;
        clr = 1'b1; px(21, 4); clr = 1'b0;
        total_n++; if (eh1 !== 1'b0 || ev1 !== 1'b0) $display("FAIL clear_alone: err_h=%0b err_v=%0b want 0/0", eh1, ev1); else pass_n++;
        px(22, 4); px(23, 4);
        for (int y = 5; y < 12; y++) line(y, 24);
        frame(12);
        total_n++; if (l1 !== 1'b1 || fc1 !== 16'd5) $display("FAIL relock2: locked=%0b count=%0d want 1/5", l1, fc1); else pass_n++;
    endtask

    task automatic test_frame_error;
        frame(11);
        total_n++; if (l1 !== 1'b1 || fc1 !== 16'd6) $display("FAIL pre_short: locked=%0b count=%0d want 1/6", l1, fc1); else pass_n++;
        frame(12);
        total_n++; if (l1 !== 1'b0 || ev1 !== 1'b1 || eh1 !== 1'b0) $display("FAIL frame_err: locked=%0b err_v=%0b err_h=%0b want 0/1/0", l1, ev1, eh1); else pass_n++;
        total_n++; if (mvt1 !== 12'd11 || mva1 !== 12'd8 || fc1 !== 16'd6) $display("FAIL frame_meas: v=%0d va=%0d count=%0d want 11/8/6", mvt1, mva1, fc1); else pass_n++;
        total_n++; if (ev0 !== 1'b1 || mvt0 !== 12'd11) $display("FAIL frame_err_hi: err_v=%0b v=%0d want 1/11", ev0, mvt0); else pass_n++;
    endtask

    task automatic test_reset_mid;
        frame(12); frame(12);
        total_n++; if (l1 !== 1'b1 || fc1 !== 16'd7 || ev1 !== 1'b1) $display("FAIL pre_reset: locked=%0b count=%0d err_v=%0b want 1/7/1", l1, fc1, ev1); else pass_n++;
        line(0, 24); line(1, 24); line(2, 24);
        for (int x = 0; x < 5; x++) px(x, 3);
        rst = 1'b1; px(5, 3); rst = 1'b0;
        total_n++; if ({l1, fd1, eh1, ev1, mht1, mha1, mvt1, mva1, cs1, fc1} !== '0) $display("FAIL mid_reset_lo: outputs=%h want 0", {l1, fd1, eh1, ev1, mht1, mha1, mvt1, mva1, cs1, fc1}); else pass_n++;
        total_n++; if ({l0, fd0, eh0, ev0, mht0, mha0, mvt0, mva0, cs0, fc0} !== '0) $display("FAIL mid_reset_hi: outputs=%h want 0", {l0, fd0, eh0, ev0, mht0, mha0, mvt0, mva0, cs0, fc0}); else pass_n++;
        for (int x = 6; x < 24; x++) px(x, 3);
        for (int y = 4; y < 12; y++) line(y, 24);
        total_n++; if (l1 !== 1'b0 || fc1 !== 16'd0) $display("FAIL one_vs: locked=%0b count=%0d want 0/0", l1, fc1); else pass_n++;
        frame(12);
        total_n++; if (l1 !== 1'b1 || fc1 !== 16'd1 || {mht1, mha1, mvt1, mva1} !== {12'd24, 12'd16, 12'd12, 12'd8} || cs1 !== 16'h0300) $display("FAIL relock_lo: locked=%0b count=%0d meas=%h sum=%h want 1/1/01801000c008/0300", l1, fc1, {mht1, mha1, mvt1, mva1}, cs1); else pass_n++;
        total_n++; if (l0 !== 1'b1 || fc0 !== 16'd1 || {mht0, mha0, mvt0, mva0} !== {12'd24, 12'd16, 12'd12, 12'd8} || cs0 !== 16'h0300) $display("FAIL relock_hi: locked=%0b count=%0d meas=%h sum=%h want 1/1/01801000c008/0300", l0, fc0, {mht0, mha0, mvt0, mva0}, cs0); else pass_n++;
    endtask

    initial begin
        test_reset;
        test_lock;
        test_checksum;
        test_line_error;
        test_clear;
        test_frame_error;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side checker for the VGA output interface. Sits on the pixel-clock domain and watches the vga_HS, vga_VS, vga_BLANK and vga_R/G/B outputs of the VGA pipeline.
- Measures line and frame timing, locks when the timing matches the configured mode, and flags timing errors.
- Produces a per-frame pixel checksum, so the face/BPM renderer can be checked in simulation and on-chip through a debug register tap.

Parameters:
- H_TOTAL, 800, expected clocks per line (HS edge to HS edge)
- H_ACTIVE, 640, expected visible pixels per visible line
- V_TOTAL, 525, expected lines per frame (HS edges between VS edges)
- V_ACTIVE, 480, expected lines per frame containing visible pixels
- SYNC_ACTIVE_LOW, 1, 1 = HS/VS asserted low; 0 = asserted high

Ports:
- clk_clk  in  1  pixel clock, same clock that drives the vga_CLK output
- reset_reset  in  1  synchronous reset, active-high
- vga_HS  in  1  horizontal sync from VGA output
- vga_VS  in  1  vertical sync from VGA output
- vga_BLANK  in  1  1 = visible pixel, 0 = blanking
- vga_R  in  8  red
- vga_G  in  8  green
- vga_B  in  8  blue
- clear_errors  in  1  one-cycle pulse; clears the sticky error flags
- locked  out  1  1 when the state machine is in LOCKED
- frame_done  out  1  one-cycle pulse when the frame measurements update
- meas_h_total  out  12  clocks in the last completed line
- meas_h_active  out  12  visible pixels in the last completed visible line
- meas_v_total  out  12  lines in the last completed frame
- meas_v_active  out  12  visible lines in the last completed frame
- frame_checksum  out  16  checksum of the last completed frame
- frame_count  out  16  frames completed while LOCKED; wraps at 65535 -> 0
- err_h  out  1  sticky horizontal timing error
- err_v  out  1  sticky vertical timing error

Behaviour:
- Input capture:
  - All video inputs are registered once.
  - An HS or VS edge is the inactive-to-active transition of the registered signal, with polarity set by SYNC_ACTIVE_LOW. The edge is detected one cycle after the pin changes.
  - Measurement registers update on the cycle after detection. Total latency from the pin edge to the output update is 2 clocks.
- Horizontal counters:
  - h_cnt and h_act are 12 bits and saturate at 4095.
  - On an HS edge cycle: line_total = h_cnt+1 and line_act = h_act + BLANK. Then h_cnt <= 0 and h_act <= 0.
  - On all other cycles: h_cnt increments, and h_act increments when the registered BLANK is 1.
- Line capture:
  - meas_h_total updates on every HS edge while the state is not SEARCH.
  - meas_h_active updates only when line_act != 0, so vertical-blank lines do not overwrite it.
- Vertical counters:
  - v_cnt counts HS edges and v_act counts lines with line_act != 0.
  - On a VS edge: meas_v_total <= v_cnt, meas_v_active <= v_act, frame_checksum <= accumulator. Then the counters and the accumulator clear.
  - An HS edge in the same cycle as a VS edge counts toward the frame that is ending.
- Checksum: a 16-bit accumulator adds R+G+B, modulo 2^16, on every cycle where the registered BLANK is 1.
- State machine (SEARCH, ACQUIRE, LOCKED):
  - SEARCH: discard all measurements. On the first VS edge go to ACQUIRE, with counters cleared.
  - ACQUIRE: on a VS edge, if meas values equal V_TOTAL/V_ACTIVE and every line in the frame matched, go to LOCKED. Otherwise stay in ACQUIRE.
  - LOCKED: any line mismatch or frame mismatch sends the state to SEARCH on the next cycle.
- Line match: line_total == H_TOTAL, and line_act is either 0 or H_ACTIVE.
- frame_done: pulses on the VS capture cycle in ACQUIRE or LOCKED only.
- frame_count: increments on each VS capture that leaves the machine in LOCKED, including the ACQUIRE->LOCKED transition.
- Error flags:
  - err_h sets on a line mismatch while in LOCKED.
  - err_v sets on a frame mismatch while in LOCKED.
  - Both are sticky until clear_errors. If a set and clear_errors occur in the same cycle, set wins.
- Reset: every output is 0, the state is SEARCH, and all counters and the accumulator are 0. Reset mid-frame discards the partial frame.
- A missing HS or VS leaves the counters saturated with no capture. The machine holds its state until the next edge, and that edge then mismatches.

Test Plan:
- Ideal 640x480 timing for 3 frames -> locked=1 two clocks after the second VS edge. At that point meas_h_total=800, meas_h_active=640, meas_v_total=525, meas_v_active=480 and frame_count=1. frame_count=2 after the third VS edge.
- Constant R=1, G=2, B=3 over a full locked frame -> frame_checksum=0x2000 (307200*6 mod 65536).
- While locked, inject one line of 801 clocks -> err_h=1, locked=0 on the next cycle, state SEARCH. After two further clean frames, locked=1 again and err_h is still 1.
- A frame with 524 lines while locked -> err_v=1, err_h=0, locked drops, frame_count is held.
- clear_errors asserted in the same cycle as a new line mismatch -> err_h stays 1. clear_errors alone -> err_h=0 the next cycle.
- Assert reset_reset mid-line while locked -> all outputs 0 the next cycle. Relock requires two VS edges. SYNC_ACTIVE_LOW=0 with inverted syncs gives identical measurements.
